// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the fifo_bank write-side arbiter.
// Combinational helpers only; no latency, no flow control.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or after rr_ptr_i, with wrap.
// Purely combinational; zero latency, no backpressure.
module rr_priority_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] rr_ptr_i,
  output logic                 any_valid_o,
  output logic [IDX_WIDTH-1:0] pick_idx_o
);

  logic [IDX_WIDTH:0]   sum;
  logic [IDX_WIDTH-1:0] idx;

  always_comb begin
    any_valid_o = 1'b0;
    pick_idx_o  = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_i} + (IDX_WIDTH+1)'(k);
      if (sum >= (IDX_WIDTH+1)'(NUM_REQ)) begin
        sum = sum - (IDX_WIDTH+1)'(NUM_REQ);
      end
      idx = sum[IDX_WIDTH-1:0];
      if (!any_valid_o && req_i[idx]) begin
        any_valid_o = 1'b1;
        pick_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_bank write port among NUM_REQ producers.
// One idle cycle to arbitrate, then up to BURST_LEN beats; stalls without advancing on fifo full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full_i,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          grant_valid,
  output logic [IDX_WIDTH-1:0]          grant_idx
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic                  any_valid;
  logic [IDX_WIDTH-1:0]  pick_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  beat;
  logic                  release_grant;

  rr_priority_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req_i       (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .any_valid_o (any_valid),
    .pick_idx_o  (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_WIDTH'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    req_ready     = '0;
    fifo_wen      = 1'b0;
    fifo_wdata    = '0;
    grant_valid   = 1'b0;
    grant_idx     = '0;
    beat          = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_GRANT;
        end
      end

      ARB_GRANT: begin
        grant_valid        = 1'b1;
        grant_idx          = grant_q;
        req_ready[grant_q] = !fifo_full_i;
        beat               = sel_valid && !fifo_full_i;
        fifo_wen           = beat;
        if (beat) begin
          fifo_wdata = sel_data;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        // An idle producer gives up the port even while the fifo is full.
        release_grant = !sel_valid ||
                        (beat && (sel_last || beat_cnt_q == CNT_W'(BURST_LEN - 1)));
        if (release_grant) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IDX_WIDTH'(rr_next(int'(grant_q), NUM_REQ));
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_ready_needs_grant : assert property (@(posedge clk) disable iff (!rst_n)
                                         (req_ready != '0) |-> grant_valid);
  a_wen_needs_grant : assert property (@(posedge clk) disable iff (!rst_n)
                                       fifo_wen |-> grant_valid);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one fifo_bank write port among NUM_REQ independent producers.
- Each producer uses a valid/ready stream with an end-of-packet marker.
- The arbiter grants one producer at a time for a bounded burst and drives the FIFO's wen/wdata.
- It stalls on FIFO full and rotates priority after every grant release.
- Sits directly in front of fifo_bank.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, data width; must equal the fifo_bank DATA_WIDTH.
- BURST_LEN, 4, maximum beats per grant before forced release (>=1).
- IDX_WIDTH, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  per-requester end of packet, qualified by valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full_i  in  1  fifo_bank full_o.
- fifo_wen  out  1  write enable to fifo_bank.
- fifo_wdata  out  DATA_WIDTH  write data to fifo_bank.
- grant_valid  out  1  a grant is currently held.
- grant_idx  out  IDX_WIDTH  index of the granted requester; valid when grant_valid=1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ARB_IDLE, rr_ptr=0, grant_q=0, beat_cnt=0.
  - Outputs are forced low while in ARB_IDLE: req_ready=0, fifo_wen=0, grant_valid=0, grant_idx=0, fifo_wdata=0.
  - A reset in mid-burst aborts the grant with no further writes; no partial-packet recovery.
- ARB_IDLE:
  - If any req_valid is high, select the first set bit searching rr_ptr, rr_ptr+1, ... with modulo-NUM_REQ wrap.
  - Register the selection into grant_q, clear beat_cnt, go to ARB_GRANT.
  - No transfer happens in this cycle.
  - Arbitration latency: valid high at edge N gives the grant visible after edge N+1; the first beat is accepted in the cycle following N+1.
- ARB_GRANT outputs:
  - grant_valid=1, grant_idx=grant_q.
  - req_ready[grant_q]=!fifo_full_i; all other ready bits are 0.
  - fifo_wen=req_valid[grant_q] && !fifo_full_i.
  - fifo_wdata=req_data slice of grant_q; it is driven 0 when fifo_wen=0.
  - Beat = cycle with fifo_wen=1; beat_cnt increments per beat (width $clog2(BURST_LEN+1)).
- Release condition, evaluated in each ARB_GRANT cycle:
  - (a) a beat with req_last[grant_q]=1; or
  - (b) a beat where beat_cnt==BURST_LEN-1; or
  - (c) req_valid[grant_q]=0, whether or not fifo_full_i is high.
- On release:
  - rr_ptr <= (grant_q+1) mod NUM_REQ; state <= ARB_IDLE.
  - The releasing beat itself is still written.
- FIFO full:
  - While fifo_full_i=1 with the granted requester still valid, hold the grant, hold beat_cnt, and write nothing.
  - Data and last must stay stable (producer obligation).
  - The burst timer does not advance while stalled.
- Throughput:
  - At most BURST_LEN beats per BURST_LEN+1 cycles; one idle arbitration cycle between grants.
- Fairness:
  - Every continuously valid requester is granted within NUM_REQ grants.
  - A requester that arrives while another holds the grant waits for release.
- No other requester's data is ever written while a grant is held.
- req_ready is never asserted in ARB_IDLE.

Decomposition:
- Package fifo_arb_pkg:
  - state_t enum logic [0:0] {ARB_IDLE, ARB_GRANT}.
  - Function rr_next(ptr, n) giving modulo increment.
- Sub-module rr_priority_pick (NUM_REQ):
  - Purely combinational rotating-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: any_valid, pick_idx.
  - Reusable for a later read-side scheduler.
- The top level holds the FSM, counters and muxing.

Test Plan:
1. Reset: rst_n=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0, fifo_wen=0, grant_valid=0 in all reset cycles; after release, the first grant goes to idx 0.
2. Requester 2 only, 3 beats 0xA1, 0xA2, 0xA3 with last on 0xA3 -> grant_idx=2 one cycle after valid; fifo_wdata is 0xA1, 0xA2, 0xA3 on consecutive cycles; release; next arbitration starts at rr_ptr=3.
3. All four valid continuously, no last, BURST_LEN=4 -> grant order 0, 1, 2, 3, 0; exactly 4 beats per grant; one idle cycle between grants; 16 writes in 20 cycles.
4. fifo_full_i=1 for 5 cycles after beat 2 of requester 1 -> req_ready and fifo_wen are 0 for those 5 cycles; grant is held; beats 3 and 4 follow with no data loss or duplication; 4 beats total.
5. Requester 0 drops valid after beat 1 while requester 3 is valid -> release; rr_ptr=1; requester 3 is granted next (1 and 2 are idle); requester 0's beat count is 1.
6. rst_n=0 for one cycle mid-burst of requester 2 -> fifo_wen=0 from that edge; state is ARB_IDLE; rr_ptr=0; the next grant goes to the lowest valid index.
